// File: rtl/char_text_buffer_pkg.sv
// Types local to the writable text-screen buffer.
package char_text_buffer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/vga_pkg.sv
// Shared character-code constants for the text overlays.
package vga_pkg;

  typedef logic [6:0] char_code_t;

  localparam char_code_t Spc = 7'h20;

  localparam char_code_t A = 7'h41, B = 7'h42, C = 7'h43, D = 7'h44, E = 7'h45, F = 7'h46;
  localparam char_code_t G = 7'h47, H = 7'h48, I = 7'h49, J = 7'h4A, K = 7'h4B, L = 7'h4C;
  localparam char_code_t M = 7'h4D, N = 7'h4E, O = 7'h4F, P = 7'h50, Q = 7'h51, R = 7'h52;
  localparam char_code_t S = 7'h53, T = 7'h54, U = 7'h55, V = 7'h56, W = 7'h57, X = 7'h58;
  localparam char_code_t Y = 7'h59, Z = 7'h5A;

  localparam char_code_t a = 7'h61, b = 7'h62, c = 7'h63, d = 7'h64, e = 7'h65, f = 7'h66;
  localparam char_code_t g = 7'h67, h = 7'h68, i = 7'h69, j = 7'h6A, k = 7'h6B, l = 7'h6C;
  localparam char_code_t m = 7'h6D, n = 7'h6E, o = 7'h6F, p = 7'h70, q = 7'h71, r = 7'h72;
  localparam char_code_t s = 7'h73, t = 7'h74, u = 7'h75, v = 7'h76, w = 7'h77, x = 7'h78;
  localparam char_code_t y = 7'h79, z = 7'h7A;

endpackage

// File: rtl/char_text_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module char_text_buffer_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [ADDR_W-1:0] ra_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  // NOTE: the array has no reset so it maps onto block/distributed RAM; the
  // owner fills it with a clear sequence instead.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wa_i] <= wd_i;
  end

  // NOTE: non-blocking assignments make a same-cycle read see the old word
  // (read-first), independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst_i) rd_q <= '0;
    else       rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/char_text_buffer.sv
// Writable COLS x ROWS character buffer with a self-clearing FSM.
// Optional write cursor with auto-increment: define TEXT_BUF_AUTOINC_EN.
module char_text_buffer
  import char_text_buffer_pkg::*;
#(
  parameter int                COLS      = 16,
  parameter int                ROWS      = 16,
  parameter int                CODE_W    = 7,
  parameter logic [CODE_W-1:0] FILL_CODE = CODE_W'(vga_pkg::Spc),
  localparam int               COL_W     = $clog2(COLS),
  localparam int               ROW_W     = $clog2(ROWS),
  localparam int               ADDR_W    = ROW_W + COL_W,
  localparam int               DEPTH     = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] char_xy,
  output logic [CODE_W-1:0] char_code,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_xy,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              clear_req,
`ifdef TEXT_BUF_AUTOINC_EN
  input  logic              wr_next,
  output logic [ADDR_W-1:0] cursor_xy,
`endif
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   clr_addr_q, clr_addr_d;
  logic              rd_ok_q;
  logic              wr_fire;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [CODE_W-1:0] ram_wd;
  logic [CODE_W-1:0] ram_rd;

  function automatic logic in_range(input logic [ADDR_W-1:0] xy);
    return (int'(xy[COL_W-1:0]) < COLS) && (int'(xy[ADDR_W-1:COL_W]) < ROWS);
  endfunction

  assign busy     = rst || (state_q == ST_CLEAR);
  assign wr_ready = !busy;
  assign wr_fire  = wr_valid && wr_ready;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clear_req) begin
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_d == (ADDR_W+1)'(DEPTH)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      rd_ok_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_ok_q    <= in_range(char_xy);
    end
  end

`ifdef TEXT_BUF_AUTOINC_EN
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              next_fire;

  // Row-major successor cell; the last visible cell wraps to {0,0}.
  function automatic logic [ADDR_W-1:0] next_cell(input logic [ADDR_W-1:0] xy);
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    col = xy[COL_W-1:0];
    row = xy[ADDR_W-1:COL_W];
    if (int'(col) >= COLS - 1) begin
      col = '0;
      row = (int'(row) >= ROWS - 1) ? '0 : row + 1'b1;
    end else begin
      col = col + 1'b1;
    end
    return {row, col};
  endfunction

  assign next_fire = wr_next && !wr_valid && wr_ready;
  assign cursor_xy = cursor_q;

  always_comb begin
    cursor_d = cursor_q;
    if (wr_fire)        cursor_d = next_cell(wr_xy);
    else if (next_fire) cursor_d = next_cell(cursor_q);
    if (clear_req)      cursor_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cursor_q <= '0;
    else     cursor_q <= cursor_d;
  end
`endif

  // Clear owns the write port; a host write can only land while idle.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = wr_xy;
    ram_wd = wr_code;
    if (state_q == ST_CLEAR) begin
      ram_we = !rst;
      ram_wa = clr_addr_q[ADDR_W-1:0];
      ram_wd = FILL_CODE;
    end else if (wr_fire) begin
      ram_we = in_range(wr_xy);
`ifdef TEXT_BUF_AUTOINC_EN
    end else if (next_fire) begin
      ram_we = in_range(cursor_q);
      ram_wa = cursor_q;
`endif
    end
  end

  char_text_buffer_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CODE_W)
  ) u_ram (
    .clk   (clk),
    .rst_i (rst),
    .we_i  (ram_we),
    .wa_i  (ram_wa),
    .wd_i  (ram_wd),
    .ra_i  (char_xy),
    .rd_o  (ram_rd)
  );

  assign char_code = rd_ok_q ? ram_rd : FILL_CODE;

endmodule
